// File: rtl/sub_share_arb_if.sv
// Request/grant, operand and result bundle for sub_share_arb.
// Borrow exists only when SUB_SHARE_ARB_BORROW_EN is defined.
interface sub_share_arb_if #(
  parameter int unsigned WIDTH = 16
);
  logic             Req0;
  logic [WIDTH-1:0] A0;
  logic [WIDTH-1:0] B0;
  logic             Req1;
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] B1;
  logic             Gnt0;
  logic             Gnt1;
  logic [WIDTH-1:0] Diff;
  logic             DValid;
  logic             DId;
  logic             Rdy;
`ifdef SUB_SHARE_ARB_BORROW_EN
  logic             Borrow;
`endif

  modport master (
    output Req0, A0, B0, Req1, A1, B1, Rdy,
    input  Gnt0, Gnt1, Diff, DValid, DId
`ifdef SUB_SHARE_ARB_BORROW_EN
    , input Borrow
`endif
  );

  modport slave (
    input  Req0, A0, B0, Req1, A1, B1, Rdy,
    output Gnt0, Gnt1, Diff, DValid, DId
`ifdef SUB_SHARE_ARB_BORROW_EN
    , output Borrow
`endif
  );
endinterface

// File: rtl/sub_share_arb.sv
// Two-port round-robin arbiter in front of one registered WIDTH-bit subtractor.
// Define SUB_SHARE_ARB_BORROW_EN to add a registered Borrow output.
module sub_share_arb #(
  parameter int unsigned WIDTH = 16
) (
  input  logic           Clk,
  input  logic           Rst,
  sub_share_arb_if.slave bus
);

  typedef enum logic {StIdle, StFull} state_e;

  state_e           state_q, state_d;
  logic             pri_q, pri_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             did_q, did_d;
  logic             acc;
  logic             gnt0, gnt1;
`ifdef SUB_SHARE_ARB_BORROW_EN
  logic             borrow_q, borrow_d;
`endif

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    pri_d   = pri_q;
    diff_d  = diff_q;
    did_d   = did_q;
`ifdef SUB_SHARE_ARB_BORROW_EN
    borrow_d = borrow_q;
`endif
    // A held result can be drained and replaced in the same cycle.
    acc = (state_q == StIdle) || bus.Rdy;

    if (!Rst && acc) begin
      if (bus.Req0 && (!bus.Req1 || !pri_q)) begin
        gnt0 = 1'b1;
      end else if (bus.Req1) begin
        gnt1 = 1'b1;
      end
    end

    if (gnt0) begin
      diff_d  = bus.A0 - bus.B0;
      did_d   = 1'b0;
      pri_d   = 1'b1;
      state_d = StFull;
`ifdef SUB_SHARE_ARB_BORROW_EN
      borrow_d = bus.A0 < bus.B0;
`endif
    end else if (gnt1) begin
      diff_d  = bus.A1 - bus.B1;
      did_d   = 1'b1;
      pri_d   = 1'b0;
      state_d = StFull;
`ifdef SUB_SHARE_ARB_BORROW_EN
      borrow_d = bus.A1 < bus.B1;
`endif
    end else if (state_q == StFull && bus.Rdy) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      pri_q   <= 1'b0;
      diff_q  <= '0;
      did_q   <= 1'b0;
`ifdef SUB_SHARE_ARB_BORROW_EN
      borrow_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      diff_q  <= diff_d;
      did_q   <= did_d;
`ifdef SUB_SHARE_ARB_BORROW_EN
      borrow_q <= borrow_d;
`endif
    end
  end

  assign bus.Gnt0   = gnt0;
  assign bus.Gnt1   = gnt1;
  assign bus.Diff   = diff_q;
  assign bus.DId    = did_q;
  assign bus.DValid = (state_q == StFull);
`ifdef SUB_SHARE_ARB_BORROW_EN
  assign bus.Borrow = borrow_q;
`endif

endmodule

// File: tb/tb_sub_share_arb.sv
// Self-checking bench for sub_share_arb: directed plan plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_sub_share_arb;
  localparam int unsigned W = 16;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  sub_share_arb_if #(.WIDTH(W)) bus ();

  sub_share_arb #(.WIDTH(W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: one result slot, a round-robin turn and the last computed values.
  logic         m_valid, m_id, m_pri, m_borrow;
  logic [W-1:0] m_diff;
  logic         eg0, eg1;
  logic         obs_g0, obs_g1, obs_valid, obs_id;
  logic [W-1:0] obs_diff;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_pri = 1'b0; m_diff = '0; m_borrow = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model, move past the rising edge.
  task automatic cycle();
    logic acc;
    @(negedge Clk);
    acc = !m_valid || bus.Rdy;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!Rst && acc) begin
      if (bus.Req0 && bus.Req1) begin
        eg0 = (m_pri == 1'b0);
        eg1 = (m_pri == 1'b1);
      end else begin
        eg0 = bus.Req0;
        eg1 = bus.Req1;
      end
    end
    obs_g0 = bus.Gnt0; obs_g1 = bus.Gnt1; obs_valid = bus.DValid;
    obs_id = bus.DId;  obs_diff = bus.Diff;
    chk("gnt0", {31'd0, obs_g0}, {31'd0, eg0});
    chk("gnt1", {31'd0, obs_g1}, {31'd0, eg1});
    chk("dvalid", {31'd0, obs_valid}, {31'd0, m_valid});
    chk("diff", {16'd0, obs_diff}, {16'd0, m_diff});
    chk("did", {31'd0, obs_id}, {31'd0, m_id});
`ifdef SUB_SHARE_ARB_BORROW_EN
    chk("borrow", {31'd0, bus.Borrow}, {31'd0, m_borrow});
`endif
    if (Rst) begin
      model_reset();
    end else if (eg0 || eg1) begin
      if (eg0) begin
        m_diff = W'(int'(bus.A0) - int'(bus.B0)); m_borrow = bus.A0 < bus.B0; m_id = 1'b0;
      end else begin
        m_diff = W'(int'(bus.A1) - int'(bus.B1)); m_borrow = bus.A1 < bus.B1; m_id = 1'b1;
      end
      m_pri   = ~m_id;
      m_valid = 1'b1;
    end else if (m_valid && bus.Rdy) begin
      m_valid = 1'b0;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0; bus.Rdy = 1'b1;
    cycle();
    Rst = 1'b0;
  endtask

  initial begin
    bus.Req0 = 1'b0; bus.Req1 = 1'b0; bus.Rdy = 1'b1;
    bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
    repeat (2) @(posedge Clk);
    #1;
    model_reset();
    Rst = 1'b0;

    // Reset state.
    cycle();
    chk("rst_dvalid", {31'd0, obs_valid}, 32'd0);
    chk("rst_diff", {16'd0, obs_diff}, 32'd0);

    // 1: single port-0 operation.
    bus.Req0 = 1'b1; bus.A0 = 16'd64; bus.B0 = 16'd8; bus.Rdy = 1'b1;
    cycle();
    chk("t1_gnt0", {31'd0, obs_g0}, 32'd1);
    bus.Req0 = 1'b0;
    cycle();
    chk("t1_diff", {16'd0, obs_diff}, 32'd56);
    chk("t1_valid", {31'd0, obs_valid}, 32'd1);
    chk("t1_did", {31'd0, obs_id}, 32'd0);
    cycle();
    chk("t1_drop", {31'd0, obs_valid}, 32'd0);

    // 2: port 1 alone, then a wrapping subtraction.
    bus.Req1 = 1'b1; bus.A1 = 16'd65; bus.B1 = 16'd8;
    cycle();
    chk("t2_gnt1", {31'd0, obs_g1}, 32'd1);
    bus.A1 = 16'd256; bus.B1 = 16'd257;
    cycle();
    chk("t2_diff", {16'd0, obs_diff}, 32'd57);
    chk("t2_did", {31'd0, obs_id}, 32'd1);
    bus.Req1 = 1'b0;
    cycle();
    chk("t2_wrap", {16'd0, obs_diff}, 32'h0000_ffff);
`ifdef SUB_SHARE_ARB_BORROW_EN
    chk("t2_borrow", {31'd0, bus.Borrow}, 32'd1);
`endif

    // 3: both ports requesting continuously from reset.
    do_reset();
    bus.Req0 = 1'b1; bus.A0 = 16'd1;  bus.B0 = 16'd0;
    bus.Req1 = 1'b1; bus.A1 = 16'd10; bus.B1 = 16'd3;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("t3_alt_gnt0", {31'd0, obs_g0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_excl", {31'd0, obs_g0 & obs_g1}, 32'd0);
      if (k > 0) chk("t3_diff", {16'd0, obs_diff}, (k % 2 == 1) ? 32'd1 : 32'd7);
    end
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    cycle();

    // 4: backpressure with a pending port-1 request.
    do_reset();
    bus.Req0 = 1'b1; bus.A0 = 16'd64; bus.B0 = 16'd8;
    cycle();
    bus.Req0 = 1'b0; bus.Rdy = 1'b0;
    bus.Req1 = 1'b1; bus.A1 = 16'd10; bus.B1 = 16'd3;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t4_hold_diff", {16'd0, obs_diff}, 32'd56);
      chk("t4_hold_gnt1", {31'd0, obs_g1}, 32'd0);
    end
    bus.Rdy = 1'b1;
    cycle();
    chk("t4_gnt1", {31'd0, obs_g1}, 32'd1);
    bus.Req1 = 1'b0;
    cycle();
    chk("t4_diff", {16'd0, obs_diff}, 32'd7);

    // 5: reset while FULL with requests pending.
    bus.Req0 = 1'b1; bus.A0 = 16'd64; bus.B0 = 16'd8;
    cycle();
    bus.Rdy = 1'b0; bus.Req1 = 1'b1;
    cycle();
    Rst = 1'b1;
    cycle();
    chk("t5_nognt", {31'd0, obs_g0 | obs_g1}, 32'd0);
    Rst = 1'b0;
    cycle();
    chk("t5_valid", {31'd0, obs_valid}, 32'd0);
    chk("t5_diff", {16'd0, obs_diff}, 32'd0);
    chk("t5_pri0", {31'd0, obs_g0}, 32'd1);
    bus.Req0 = 1'b0; bus.Req1 = 1'b0; bus.Rdy = 1'b1;
    cycle();

    // 6: port 0 withdraws while blocked.
    bus.Req1 = 1'b1; bus.A1 = 16'd5; bus.B1 = 16'd2;
    cycle();
    bus.Req1 = 1'b0; bus.Rdy = 1'b0; bus.Req0 = 1'b1;
    cycle();
    chk("t6_nognt", {31'd0, obs_g0}, 32'd0);
    bus.Req0 = 1'b0;
    cycle();
    bus.Rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("t6_did", {31'd0, obs_id}, 32'd1);
    end

    // Randomized traffic; requesters obey hold-until-grant, may withdraw.
    for (int n = 0; n < 3000; n++) begin
      Rst     = ($urandom_range(0, 59) == 0);
      bus.Rdy = ($urandom_range(0, 3) != 0);
      cycle();
      if (obs_g0 || (bus.Req0 && $urandom_range(0, 15) == 0)) bus.Req0 = 1'b0;
      else if (!bus.Req0 && $urandom_range(0, 2) == 0) begin
        bus.Req0 = 1'b1; bus.A0 = W'($urandom); bus.B0 = W'($urandom);
      end
      if (obs_g1 || (bus.Req1 && $urandom_range(0, 15) == 0)) bus.Req1 = 1'b0;
      else if (!bus.Req1 && $urandom_range(0, 2) == 0) begin
        bus.Req1 = 1'b1; bus.A1 = W'($urandom); bus.B1 = W'($urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
